// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC32 receive-side checker.
// Holds the default widths, the status FSM encoding and the CRC32
// algorithm constants (MSB-first, non-reflected, init and final XOR all ones).
package crc32_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned DEF_CRC_WIDTH  = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } st_e;

endpackage

// File: rtl/crc32_gen.sv
// Combinational CRC32 generator, shared with the link CRC32 encoder.
// The data word is consumed MSB first (bit DATA_WIDTH-1 first).
// Ports:
//   i_data   - data word to protect
//   o_crc_c  - CRC32 of i_data (combinational)
module crc32_gen
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CRC_WIDTH  = DEF_CRC_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CRC_WIDTH-1:0]  o_crc_c
);

  // Bit-serial LFSR unrolled across the whole word.
  always_comb begin : crc_calc
    logic [CRC_WIDTH-1:0]  v_crc;
    logic [DATA_WIDTH-1:0] v_data;
    logic                  v_fb;
    v_crc  = CRC_WIDTH'(CRC_INIT);
    v_data = i_data;
    v_fb   = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      v_fb   = v_crc[CRC_WIDTH-1] ^ v_data[DATA_WIDTH-1];
      v_crc  = {v_crc[CRC_WIDTH-2:0], 1'b0} ^ (v_fb ? CRC_WIDTH'(CRC_POLY) : '0);
      v_data = {v_data[DATA_WIDTH-2:0], 1'b0};
    end
    o_crc_c = v_crc ^ CRC_WIDTH'(CRC_XOROUT);
  end

endmodule

// File: rtl/crc32_dec.sv
// Receive-side CRC32 checker.
// Recomputes the CRC over data_i, compares it with checksum_i, and registers
// the word plus a mismatch flag in a one-entry valid/ready output stage.
// Keeps a sticky error status (FSM OK/ERR) and a saturating error counter.
// Optional macro CRC32_DEC_DROP_EN: mismatched words are counted but not
// forwarded, and error_o is tied low.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   valid_i/ready_o, data_i, checksum_i - input word handshake
//   valid_o/ready_i, data_o, error_o    - output word handshake
//   err_sticky_o, err_cnt_o, clr_i      - error status and its clear
module crc32_dec
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CRC_WIDTH  = DEF_CRC_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CRC_WIDTH-1:0]  checksum_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  error_o,
  output logic                  err_sticky_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  input  logic                  clr_i
);

  logic [CRC_WIDTH-1:0]  w_crc;
  logic                  w_mismatch;
  logic                  w_accept;
  logic                  w_acc_err;
  logic                  w_load;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;
  st_e                   r_state;
  st_e                   w_state_nxt;

  crc32_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .CRC_WIDTH  (CRC_WIDTH)
  ) u_gen (
    .i_data  (data_i),
    .o_crc_c (w_crc)
  );

  assign w_mismatch = (w_crc != checksum_i);
  assign ready_o    = !r_valid || ready_i;
  assign w_accept   = valid_i && ready_o;
  assign w_acc_err  = w_accept && w_mismatch;

`ifdef CRC32_DEC_DROP_EN
  assign w_load  = w_accept && !w_mismatch;
  assign error_o = 1'b0;
`else
  logic r_error;

  assign w_load  = w_accept;
  assign error_o = r_error;

  // Mismatch flag travels with the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_load) begin
      r_error <= w_mismatch;
    end
  end
`endif

  // Output stage valid: reload on accept, drain on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Data payload carries no reset; it is qualified by valid_o.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= data_i;
    end
  end

  // Saturating error counter; an accepted mismatch overrides a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_acc_err) begin
      if (clr_i) begin
        r_cnt <= CNT_WIDTH'(1);
      end else if (!(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end else if (clr_i) begin
      r_cnt <= '0;
    end
  end

  // Status FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OK: begin
        if (w_acc_err) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        if (!w_acc_err && clr_i) begin
          w_state_nxt = ST_OK;
        end
      end
      default: w_state_nxt = ST_OK;
    endcase
  end

  assign valid_o      = r_valid;
  assign data_o       = r_data;
  assign err_cnt_o    = r_cnt;
  assign err_sticky_o = (r_state == ST_ERR);

endmodule

// File: tb/tb_crc32_dec.sv
// Self-checking bench for crc32_dec (error counter built 4 bits wide).
module tb_crc32_dec;

  localparam int unsigned DW = 512;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic [CW-1:0] checksum_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic          error_o;
  logic          err_sticky_o;
  logic [NW-1:0] err_cnt_o;
  logic          clr_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  crc32_dec #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .checksum_i   (checksum_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .error_o      (error_o),
    .err_sticky_o (err_sticky_o),
    .err_cnt_o    (err_cnt_o),
    .clr_i        (clr_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference CRC (byte table, CRC-32/BZIP2 parameters)
  logic [31:0] tbl [256];

  task automatic build_tbl();
    for (int b = 0; b < 256; b++) begin
      logic [31:0] c;
      c = 32'(b) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      tbl[b] = c;
    end
  endtask

  function automatic logic [31:0] crc_bytes(input logic [7:0] b [64], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = (c << 8) ^ tbl[c[31:24] ^ b[i]];
    return c ^ 32'hFFFFFFFF;
  endfunction

  // Word is sent as 64 bytes, most significant byte first.
  function automatic logic [31:0] crc_word(input logic [DW-1:0] d);
    logic [7:0]    b [64];
    logic [DW-1:0] t;
    t = d;
    for (int i = 0; i < 64; i++) begin
      b[i] = t[DW-1 -: 8];
      t    = t << 8;
    end
    return crc_bytes(b, 64);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // ---------------- behavioural model: queue of words awaiting transfer
  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } item_t;

  item_t q[$];
  int    m_cnt;
  bit    m_sticky;

  initial begin
    m_cnt = 0; m_sticky = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete(); m_cnt = 0; m_sticky = 0;
      end else begin
        bit rdy, acc, mis;
        rdy = (q.size() == 0) || ready_i;
        acc = valid_i && rdy;
        mis = acc && (crc_word(data_i) != checksum_i);
        if (q.size() > 0 && ready_i) void'(q.pop_front());
        if (acc) begin
`ifdef CRC32_DEC_DROP_EN
          if (!mis) q.push_back('{data: data_i, err: 1'b0});
`else
          q.push_back('{data: data_i, err: mis});
`endif
        end
        if (mis) begin
          m_cnt    = clr_i ? 1 : ((m_cnt < (1 << NW) - 1) ? m_cnt + 1 : m_cnt);
          m_sticky = 1;
        end else if (clr_i) begin
          m_cnt = 0; m_sticky = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !done) begin
        chk("cyc_valid_o", DW'(valid_o), DW'(q.size() != 0));
        chk("cyc_ready_o", DW'(ready_o), DW'((q.size() == 0) || ready_i));
        chk("cyc_err_cnt", DW'(err_cnt_o), DW'(m_cnt));
        chk("cyc_sticky", DW'(err_sticky_o), DW'(m_sticky));
        if (q.size() != 0) begin
          chk("cyc_data_o", data_o, q[0].data);
          chk("cyc_error_o", DW'(error_o), DW'(q[0].err));
        end
      end
    end
  end

  // ---------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input bit bad, input bit clr);
    valid_i    = 1'b1;
    data_i     = d;
    checksum_i = crc_word(d) ^ (bad ? 32'h1 : 32'h0);
    clr_i      = clr;
    cyc();
    clr_i      = 1'b0;
  endtask

  logic [DW-1:0] w1, w2, wa;

  initial begin
    logic [7:0] pin [64];
    rst = 1'b1; valid_i = 0; data_i = '0; checksum_i = '0; ready_i = 1; clr_i = 0;
    build_tbl();

    // Pin the reference CRC with the standard check string "123456789".
    for (int i = 0; i < 64; i++) pin[i] = 8'h00;
    for (int i = 0; i < 9; i++) pin[i] = 8'(8'h31 + i);
    chk("model_check_str", DW'(crc_bytes(pin, 9)), DW'(32'hFC891918));

    cyc(); cyc();
    chk("rst_valid_o", DW'(valid_o), DW'(0));
    chk("rst_error_o", DW'(error_o), DW'(0));
    chk("rst_cnt", DW'(err_cnt_o), DW'(0));
    chk("rst_sticky", DW'(err_sticky_o), DW'(0));
    chk("rst_ready_o", DW'(ready_o), DW'(1));
    rst = 1'b0;
    cyc();

    // Clean all-zero word.
    put('0, 0, 0);
    valid_i = 0;
    chk("clean_valid", DW'(valid_o), DW'(1));
    chk("clean_data", data_o, '0);
    chk("clean_error", DW'(error_o), DW'(0));
    chk("clean_cnt", DW'(err_cnt_o), DW'(0));
    chk("clean_sticky", DW'(err_sticky_o), DW'(0));
    cyc();

    // Corrupted checksum.
    wa = {64{8'hA5}};
    put(wa, 1, 0);
    valid_i = 0;
`ifdef CRC32_DEC_DROP_EN
    chk("bad_valid", DW'(valid_o), DW'(0));
`else
    chk("bad_valid", DW'(valid_o), DW'(1));
    chk("bad_error", DW'(error_o), DW'(1));
`endif
    chk("bad_cnt", DW'(err_cnt_o), DW'(1));
    chk("bad_sticky", DW'(err_sticky_o), DW'(1));
    cyc();

    // Backpressure for three cycles, then transfer and reload together.
    w1 = {16{32'h12345678}};
    w2 = {16{32'hCAFEF00D}};
    put(w1, 0, 0);
    valid_i = 1; data_i = w2; checksum_i = crc_word(w2); ready_i = 0;
    #1;
    repeat (3) begin
      chk("bp_ready_o", DW'(ready_o), DW'(0));
      chk("bp_data_hold", data_o, w1);
      chk("bp_valid_hold", DW'(valid_o), DW'(1));
      cyc();
    end
    ready_i = 1;
    #1;
    chk("bp_ready_rel", DW'(ready_o), DW'(1));
    cyc();
    valid_i = 0;
    chk("bp_reload_data", data_o, w2);
    chk("bp_reload_valid", DW'(valid_o), DW'(1));
    cyc();
    chk("bp_drain_valid", DW'(valid_o), DW'(0));

    // Clear, then 8 back-to-back words with words 2 and 5 corrupted.
    clr_i = 1; cyc(); clr_i = 0;
    chk("clr_cnt", DW'(err_cnt_o), DW'(0));
    chk("clr_sticky", DW'(err_sticky_o), DW'(0));
    for (int i = 0; i < 8; i++) begin
      put({16{$urandom}}, (i == 2 || i == 5), 0);
`ifndef CRC32_DEC_DROP_EN
      chk("b2b_valid", DW'(valid_o), DW'(1));
      chk("b2b_error", DW'(error_o), DW'(i == 2 || i == 5));
`endif
    end
    valid_i = 0;
    chk("b2b_cnt", DW'(err_cnt_o), DW'(2));

    // Clear race: accepted mismatch wins over clr_i.
    clr_i = 1; cyc(); clr_i = 0;
    for (int i = 0; i < 5; i++) put({16{$urandom}}, 1, 0);
    chk("race_pre_cnt", DW'(err_cnt_o), DW'(5));
    put({16{$urandom}}, 1, 1);
    valid_i = 0;
    chk("race_cnt", DW'(err_cnt_o), DW'(1));
    chk("race_sticky", DW'(err_sticky_o), DW'(1));
    clr_i = 1; cyc(); clr_i = 0;
    chk("clr_only_cnt", DW'(err_cnt_o), DW'(0));
    chk("clr_only_sticky", DW'(err_sticky_o), DW'(0));

    // Saturation at 2^4-1.
    for (int i = 0; i < 20; i++) put({16{$urandom}}, 1, 0);
    chk("sat_cnt", DW'(err_cnt_o), DW'(15));
    chk("sat_sticky", DW'(err_sticky_o), DW'(1));

    // Asynchronous reset mid-stream, checked before the next clock edge.
    put({16{$urandom}}, 0, 0);
    put({16{$urandom}}, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_valid", DW'(valid_o), DW'(0));
    chk("arst_cnt", DW'(err_cnt_o), DW'(0));
    chk("arst_sticky", DW'(err_sticky_o), DW'(0));
    chk("arst_error", DW'(error_o), DW'(0));
    valid_i = 0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("post_rst_valid", DW'(valid_o), DW'(0));

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc32_dec.md
Name: crc32_dec

Overview:
Receive-side CRC32 checker, the counterpart of the link CRC32 encoder. It accepts a 512-bit data word with its transmitted 32-bit checksum and recomputes the CRC over the data. It compares the two, registers the data with a per-word error flag behind a one-entry valid/ready output stage, and keeps sticky error status and a saturating error count for the link controller.

Parameters:
DATA_WIDTH, 512, width of protected data word
CRC_WIDTH, 32, checksum width; must match CRC32 generator
CNT_WIDTH, 16, width of saturating error counter

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  input word valid
ready_o  output  1  block can accept input this cycle
data_i  input  DATA_WIDTH  received data word
checksum_i  input  CRC_WIDTH  received checksum
valid_o  output  1  output word valid
ready_i  input  1  downstream accepts output
data_o  output  DATA_WIDTH  registered data word
error_o  output  1  CRC mismatch flag for the word on data_o
err_sticky_o  output  1  set on any mismatch; held until cleared
err_cnt_o  output  CNT_WIDTH  number of mismatched words, saturating
clr_i  input  1  synchronous clear of err_sticky_o and err_cnt_o

Behaviour:
- Reset, asynchronous, on rst=1: valid_o=0, error_o=0, err_sticky_o=0, err_cnt_o=0, status FSM=OK. data_o is undefined (X) after reset.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - Input is accepted when valid_i && ready_o.
  - Output transfers when valid_o && ready_i.
  - valid_o, data_o and error_o stay stable while valid_o && !ready_i.
- Compute: the CRC generator runs combinationally on data_i and is compared with checksum_i in the same cycle. mismatch = (computed != checksum_i).
- Latency: one cycle. A word accepted in cycle N appears on data_o/error_o with valid_o=1 in cycle N+1.
- Throughput: one word per cycle when ready_i is held high. A simultaneous output transfer and input accept reloads the stage with no bubble.
- If no accept occurs and the output transfers, valid_o falls to 0 next cycle.
- Counter: on each accepted word with mismatch, err_cnt_o increments by 1 and saturates at 2^CNT_WIDTH-1. Counting happens at accept, not at output transfer.
- Status FSM, states OK and ERR:
  - OK -> ERR on an accepted mismatch.
  - ERR -> OK on clr_i.
  - err_sticky_o = (state == ERR).
- Clear: clr_i zeroes err_cnt_o next cycle. If clr_i and an accepted mismatch occur in the same cycle, the mismatch wins: counter = 1, state = ERR.
- Accepts with valid_i while ready_o=0 are ignored; the upstream must hold data.
- Reset mid-transfer drops the in-flight word.

Optional Feature:
CRC32_DEC_DROP_EN
- Defined: accepted words with a mismatch are counted and flagged in status but not loaded into the output stage. valid_o stays 0 for them, and error_o is tied to 0.
- Undefined (default): every accepted word is forwarded with error_o carrying the mismatch result.

Decomposition:
- Package crc32_pkg: DATA_WIDTH/CRC_WIDTH defaults, status FSM enum (ST_OK, ST_ERR), CRC32 polynomial constant 32'h04C11DB7.
- Sub-module: reuse the existing CRC32_GEN combinational generator, instantiated once on data_i. No other sub-modules.

Test Plan:
- Clean word: data_i=512'h0, checksum_i=CRC32_GEN(0), valid_i=1, ready_i=1 -> next cycle valid_o=1, data_o=0, error_o=0, err_cnt_o=0, err_sticky_o=0.
- Corrupt checksum: data_i=512'hA5 repeated, checksum_i=CRC32_GEN(data) ^ 32'h1 -> error_o=1, err_cnt_o=1, err_sticky_o=1. With CRC32_DEC_DROP_EN defined: valid_o stays 0, err_cnt_o=1.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1 -> ready_o=0, data_o held stable. Then ready_i=1 with a new input -> transfer and reload in the same cycle, no bubble.
- Back-to-back 8 words, ready_i=1, words 2 and 5 corrupted -> 8 outputs on consecutive cycles, error_o high only on words 2 and 5, err_cnt_o=2.
- Clear race: clr_i=1 in the same cycle as an accepted mismatch with err_cnt_o=5 -> next cycle err_cnt_o=1, err_sticky_o=1. clr_i alone -> err_cnt_o=0, err_sticky_o=0.
- Saturation/reset: CNT_WIDTH=4, 20 corrupted words -> err_cnt_o=15. Assert rst mid-stream -> valid_o, err_cnt_o and err_sticky_o go to 0 immediately, without waiting for a clock edge.
